bcd_scan_decoder: RTL



---
 rtl/bcd_scan_decoder_pkg.sv | 22 ++
 rtl/bcd_scan_decoder_if.sv | 27 ++
 rtl/bcd_scan_decoder_dec_bcd10.sv | 18 +
 rtl/bcd_scan_decoder.sv | 116 +++++++++++
 4 files changed

// File: rtl/bcd_scan_decoder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dec_pkg : shared BCD-to-decimal constants and helper functions              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package dec_pkg;

  localparam logic [9:0] DEC_OFF = 10'b11_1111_1111;

  function automatic logic is_bcd_valid(input logic [3:0] code);
    return code < 4'd10;
  endfunction

  function automatic logic [9:0] bcd_to_dec10_n(input logic [3:0] code);
    logic [9:0] dec_n;
    dec_n = DEC_OFF;
    if (is_bcd_valid(code)) dec_n = ~(10'd1 << code);
    return dec_n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_scan_decoder_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bcd_scan_decoder_if : digit input and lamp-drive bundle of the scanner      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface bcd_scan_decoder_if #(
  parameter int NUM_DIG = 4
);
  logic                   en;
  logic [4*NUM_DIG-1:0]   entrada;
  logic                   clr_erro;
  logic [9:0]             saida;
  logic [NUM_DIG-1:0]     sel;
  logic                   frame_tick;
  logic                   erro;

  modport master (
    output en, entrada, clr_erro,
    input  saida, sel, frame_tick, erro
  );

  modport slave (
    input  en, entrada, clr_erro,
    output saida, sel, frame_tick, erro
  );
endinterface
`default_nettype wire

// File: rtl/bcd_scan_decoder_dec_bcd10.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dec_bcd10 : combinational 4-to-10 active-low decimal decoder               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module dec_bcd10
  import dec_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [9:0] dec_n,
  output logic       valid
);

  assign dec_n = bcd_to_dec10_n(bcd);
  assign valid = is_bcd_valid(bcd);

endmodule
`default_nettype wire

// File: rtl/bcd_scan_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bcd_scan_decoder : multiplexed BCD lamp scanner with blanking and error    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module bcd_scan_decoder
  import dec_pkg::*;
#(
  parameter int NUM_DIG  = 4,
  parameter int DIV      = 1000,
  parameter int DEAD     = 2,
  parameter int BLANK_LZ = 1
) (
  input  logic               clk,
  input  logic               rst,
  bcd_scan_decoder_if.slave  bus
);

  localparam int IDX_W = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
  localparam int PRE_W = $clog2(DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIG - 1);

  logic [PRE_W-1:0]       r_presc;
  logic [IDX_W-1:0]       r_idx;
  logic [4*NUM_DIG-1:0]   r_snap;
  logic                   r_primed;
  logic [9:0]             r_saida;
  logic [NUM_DIG-1:0]     r_sel;
  logic                   r_tick;
  logic                   r_erro;

  logic [NUM_DIG-1:0]     w_hi_zero;
  logic [3:0]             w_d;
  logic                   w_hz;
  logic [9:0]             w_dec;
  logic                   w_valid;
  logic                   w_live;
  logic                   w_wrap;
  logic                   w_cap;
  logic                   w_blank;
  logic [NUM_DIG-1:0]     w_sel_n;

  // w_hi_zero[i]: every digit above slot i is zero, so slot i holds a leading zero
  for (genvar i = 0; i < NUM_DIG; i++) begin : g_hi_zero
    if (i == NUM_DIG - 1) begin : g_top
      assign w_hi_zero[i] = 1'b1;
    end else begin : g_mid
      assign w_hi_zero[i] = ~|r_snap[4*NUM_DIG-1:4*(i+1)];
    end
  end

  always_comb begin
    w_d  = 4'd0;
    w_hz = 1'b0;
    for (int i = 0; i < NUM_DIG; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_d  = r_snap[4*i +: 4];
        w_hz = w_hi_zero[i];
      end
    end
  end

  dec_bcd10 u_dec (
    .bcd   (w_d),
    .dec_n (w_dec),
    .valid (w_valid)
  );

  if (DEAD == 0) begin : g_nodead
    assign w_live = bus.en;
  end else begin : g_dead
    assign w_live = bus.en && (r_presc >= PRE_W'(DEAD));
  end

  assign w_wrap  = (r_presc == PRE_LAST);
  assign w_cap   = bus.en && (!r_primed || (w_wrap && (r_idx == IDX_LAST)));
  assign w_blank = (BLANK_LZ != 0) && (w_d == 4'd0) && w_hz && (r_idx != '0);
  assign w_sel_n = w_live ? ~(NUM_DIG'(1) << r_idx) : '1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc  <= '0;
      r_idx    <= '0;
      r_snap   <= '0;
      r_primed <= 1'b0;
      r_saida  <= DEC_OFF;
      r_sel    <= '1;
      r_tick   <= 1'b0;
      r_erro   <= 1'b0;
    end else begin
      if (bus.en) begin
        r_primed <= 1'b1;
        if (w_wrap) begin
          r_presc <= '0;
          r_idx   <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
        end else begin
          r_presc <= r_presc + PRE_W'(1);
        end
      end
      if (w_cap) r_snap <= bus.entrada;
      r_tick  <= w_cap;
      r_saida <= (bus.en && !w_blank) ? w_dec : DEC_OFF;
      r_sel   <= w_sel_n;
      // a fresh invalid code outranks a simultaneous clear
      r_erro  <= (bus.en && !w_valid) || (r_erro && !bus.clr_erro);
    end
  end

  assign bus.saida      = r_saida;
  assign bus.sel        = r_sel;
  assign bus.frame_tick = r_tick;
  assign bus.erro       = r_erro;

endmodule
`default_nettype wire
